sar_search: RTL and testbench



---
 rtl/sar_search.sv | 91 +++++++++
 tb/tb_sar_search.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sar_search.sv
// Successive-approximation search driver. Steps a trial value onto the
// comparator B operand one bit per clock, MSB first, keeping each bit
// when the comparator reports A >= trial. After WIDTH decisions the
// trial equals the unknown A operand and is published on result.
module sar_search #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             cmp_ge,
    output logic             cmp_en,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] TOP_IDX = IW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        TEST = 1'b1
    } state_t;

    state_t            state;
    logic [IW-1:0]     idx;
    logic [WIDTH-1:0]  decided;   // trial with the current bit resolved
    logic [WIDTH-1:0]  next_try;  // decided plus the next lower bit set
    logic [IW-1:0]     idx_m1;

    // Comparator enable and busy both mark the TEST state
    assign cmp_en = (state == TEST);
    assign busy   = (state == TEST);

    // Resolve the bit under test and prepare the next trial
    always_comb begin
        decided      = trial;
        decided[idx] = cmp_ge;
        idx_m1       = idx - IW'(1);
        next_try     = decided;
        if (idx != '0) begin
            next_try[idx_m1] = 1'b1;
        end
    end

    // Search FSM: one comparator decision per clock while in TEST
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            trial  <= '0;
            result <= '0;
            idx    <= TOP_IDX;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    trial <= '0;
                    if (start) begin
                        trial          <= '0;
                        trial[TOP_IDX] <= 1'b1;
                        idx            <= TOP_IDX;
                        state          <= TEST;
                    end
                end
                TEST: begin
                    if (abort) begin
                        trial <= '0;
                        state <= IDLE;
                    end else if (idx != '0) begin
                        trial <= next_try;
                        idx   <= idx_m1;
                    end else begin
                        result <= decided;
                        done   <= 1'b1;
                        trial  <= '0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    trial <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search: a behavioural comparator closes the
// loop, and expected trials/results come from a direct arithmetic model of
// binary search over the unknown value.
module tb_sar_search;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic         cmp_ge;
    logic         cmp_en;
    logic [W-1:0] trial;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    logic [W-1:0] a;
    logic [W-1:0] exp_result;
    int           errors = 0;
    int           checks = 0;
    int           done_seen = 0;
    int           done_mark;

    sar_search #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .abort  (abort),
        .cmp_ge (cmp_ge),
        .cmp_en (cmp_en),
        .trial  (trial),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    // Behavioural comparator on the far side of the search
    assign cmp_ge = (a >= trial);

    always #5 clk = ~clk;

    // Count done pulses, sampled away from the active edge
    always @(negedge clk) begin
        if (done === 1'b1) done_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Trial presented at TEST step k: the top k bits of A already decided,
    // plus the bit under test set.
    function automatic logic [W-1:0] model_trial(input logic [W-1:0] v, input int k);
        int unsigned keep;
        int unsigned full;
        full = (1 << W) - 1;
        keep = full & ~((1 << (W - k)) - 1);
        return W'((32'(v) & keep) | (1 << (W - 1 - k)));
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_busy"},   32'(busy),   32'(0));
        check({tag, "_cmp_en"}, 32'(cmp_en), 32'(0));
        check({tag, "_trial"},  32'(trial),  32'(0));
        check({tag, "_done"},   32'(done),   32'(0));
        check({tag, "_result"}, 32'(result), 32'(exp_result));
    endtask

    // Runs one search. Ends at the done sample on completion, or one cycle
    // after the abort edge when abort_at >= 0.
    task automatic search(input logic [W-1:0] av, input int abort_at, input int restart_at);
        a = av;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < W; k++) begin
            check("trial",   32'(trial),  32'(model_trial(av, k)));
            check("busy",    32'(busy),   32'(1));
            check("cmp_en",  32'(cmp_en), 32'(1));
            check("no_done", 32'(done),   32'(0));
            check("held",    32'(result), 32'(exp_result));
            if (k == restart_at) start = 1'b1;
            if (k == abort_at) abort = 1'b1;
            tick();
            start = 1'b0;
            abort = 1'b0;
            if (k == abort_at) begin
                check_idle("abort");
                return;
            end
        end
        exp_result = av;
        check("done",      32'(done),   32'(1));
        check("result",    32'(result), 32'(exp_result));
        check("end_busy",  32'(busy),   32'(0));
        check("end_trial", 32'(trial),  32'(0));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        a = '0;
        exp_result = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_idle("post_reset");

        // Reset mid-search with start held high
        a = 8'h33;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("pre_rst_busy", 32'(busy), 32'(1));
        done_mark = done_seen;
        rst_n = 1'b0;
        start = 1'b1;
        tick();
        tick();
        check_idle("in_reset");
        rst_n = 1'b1;
        start = 1'b0;
        tick();
        check_idle("released");
        check("rst_no_done", 32'(done_seen - done_mark), 32'(0));

        // Main directed search, done exactly one cycle
        done_mark = done_seen;
        search(8'hA5, -1, -1);
        tick();
        check("done_once", 32'(done_seen - done_mark), 32'(1));
        check_idle("after_a5");

        // Boundaries
        search(8'h00, -1, -1);
        tick();
        search(8'hFF, -1, -1);
        tick();
        search(8'h80, -1, -1);
        tick();

        // start during TEST ignored, then back-to-back start in the done cycle
        search(8'h3C, -1, 2);
        search(8'h11, -1, -1);
        tick();
        check_idle("b2b");

        // Abort in the 4th TEST cycle, then abort on the final decision
        search(8'hA5, -1, -1);
        tick();
        done_mark = done_seen;
        search(8'h5A, 3, -1);
        tick();
        check_idle("abort4_idle");
        search(8'h5A, W - 1, -1);
        tick();
        check_idle("abort_last_idle");
        check("abort_no_done", 32'(done_seen - done_mark), 32'(0));

        // Abort in IDLE has no effect; start still accepted afterwards
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("idle_abort");

        // Reset during TEST
        a = 8'h77;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        done_mark = done_seen;
        rst_n = 1'b0;
        tick();
        exp_result = '0;
        check_idle("rst_test");
        rst_n = 1'b1;
        tick();
        check("rst_test_no_done", 32'(done_seen - done_mark), 32'(0));
        search(8'h77, -1, -1);
        tick();

        // Randomised searches with occasional aborts and ignored restarts
        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] av;
            int ab;
            int rs;
            av = W'($urandom_range(0, (1 << W) - 1));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 1)) : -1;
            rs = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, W - 1)) : -1;
            search(av, ab, rs);
            if ($urandom_range(0, 1) == 1) tick();
        end
        tick();
        check_idle("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
